// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures an incoming PWM waveform. Reports the period and the
//               high time in clk cycles, and the duty cycle as an integer
//               percent (floor, 0-100) computed by a multi-cycle divider.
//               Flags a stuck input when no rising edge is seen for TIMEOUT
//               cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [7:0]       duty_cycle,
  output logic             valid,
  output logic             stuck,
  output logic             overrun
);

  // Numerator hi*100 needs 7 extra bits; one quotient bit per divider step.
  localparam int C_NUM_W  = CNT_W + 7;
  localparam int C_STEP_W = $clog2(C_NUM_W + 1);

  localparam logic [CNT_W-1:0]    C_TIMEOUT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]    C_CNT_ONE   = CNT_W'(1);
  localparam logic [C_NUM_W-1:0]  C_HUNDRED   = C_NUM_W'(100);
  localparam logic [C_STEP_W-1:0] C_LAST_STEP = C_STEP_W'(C_NUM_W - 1);
  localparam logic [C_STEP_W-1:0] C_STEP_ONE  = C_STEP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_DIVIDE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0]     per_lat_q, per_lat_d;
  logic [CNT_W-1:0]     hi_div_q, hi_div_d;
  logic [C_NUM_W-1:0]   num_q, num_d;
  logic [C_NUM_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic [C_STEP_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [CNT_W-1:0]     high_time_q, high_time_d;
  logic [7:0]           duty_q, duty_d;
  logic                 valid_q, valid_d;
  logic                 stuck_q, stuck_d;
  logic                 overrun_q, overrun_d;

  logic                 w_rise, w_fall, w_timeout;
  logic [CNT_W:0]       w_rem_shift;
  logic                 w_rem_ge;
  logic [CNT_W-1:0]     w_rem_sub;
  logic [C_NUM_W-1:0]   w_quo_next;
  logic [7:0]           w_duty_sat;

  // Edge detection, divider datapath and the timeout qualifier.
  always_comb begin
    w_rise      = sync2_q & ~prev_q;
    w_fall      = ~sync2_q & prev_q;
    w_rem_shift = {rem_q, num_q[C_NUM_W-1]};
    w_rem_ge    = (w_rem_shift >= {1'b0, per_lat_q});
    // The true difference is below per_lat, so the low CNT_W bits are exact.
    w_rem_sub   = w_rem_shift[CNT_W-1:0] - per_lat_q;
    w_quo_next  = {quo_q[C_NUM_W-2:0], w_rem_ge};
    w_duty_sat  = (w_quo_next > C_HUNDRED) ? 8'd100 : w_quo_next[7:0];
    // A rise in the same cycle wins; an already-reported stall in IDLE is not
    // reported again; DIVIDE defers the timeout until its result is out.
    w_timeout   = (cnt_q == C_TIMEOUT) && !w_rise && (state_q != S_DIVIDE) &&
                  !((state_q == S_IDLE) && stuck_q);
  end

  // Next-state logic for the counter, latches, divider and the measurement FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = w_rise ? C_CNT_ONE :
                  ((cnt_q < C_TIMEOUT) ? cnt_q + C_CNT_ONE : cnt_q);
    hi_lat_d    = w_fall ? cnt_q : hi_lat_q;
    per_lat_d   = per_lat_q;
    hi_div_d    = hi_div_q;
    num_d       = num_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    step_d      = step_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    duty_d      = duty_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;
    overrun_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_rise) begin
          state_d = S_ARMED;
        end else if (w_timeout) begin
          stuck_d     = 1'b1;
          period_d    = '0;
          high_time_d = '0;
          duty_d      = sync2_q ? 8'd100 : 8'd0;
          valid_d     = 1'b1;
        end
      end
      S_ARMED: begin
        if (w_rise) begin
          // hi_lat belongs to this period; snapshot it so a fall during the
          // divide can start latching the next period's high time.
          per_lat_d = cnt_q;
          hi_div_d  = hi_lat_q;
          num_d     = {7'd0, hi_lat_q} * C_HUNDRED;
          quo_d     = '0;
          rem_d     = '0;
          step_d    = '0;
          state_d   = S_DIVIDE;
        end else if (w_timeout) begin
          stuck_d     = 1'b1;
          period_d    = '0;
          high_time_d = '0;
          duty_d      = sync2_q ? 8'd100 : 8'd0;
          valid_d     = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DIVIDE: begin
        overrun_d = w_rise;
        num_d     = {num_q[C_NUM_W-2:0], 1'b0};
        rem_d     = w_rem_ge ? w_rem_sub : w_rem_shift[CNT_W-1:0];
        quo_d     = w_quo_next;
        step_d    = step_q + C_STEP_ONE;
        if (step_q == C_LAST_STEP) begin
          period_d    = per_lat_q;
          high_time_d = hi_div_q;
          duty_d      = w_duty_sat;
          valid_d     = 1'b1;
          stuck_d     = 1'b0;
          state_d     = S_ARMED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All state, including the input synchronizer, with async assert reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      cnt_q       <= '0;
      hi_lat_q    <= '0;
      per_lat_q   <= '0;
      hi_div_q    <= '0;
      num_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      step_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      duty_q      <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= pwm_in;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      cnt_q       <= cnt_d;
      hi_lat_q    <= hi_lat_d;
      per_lat_q   <= per_lat_d;
      hi_div_q    <= hi_div_d;
      num_q       <= num_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      step_q      <= step_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
      overrun_q   <= overrun_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign duty_cycle = duty_q;
  assign valid      = valid_q;
  assign stuck      = stuck_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture
// Description : Directed scoreboard bench for pwm_capture. Pin-level events
//               are turned into expected results (value and arrival cycle)
//               by a small behavioural model and checked when they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;
  localparam int LAT     = CNT_W + 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic [7:0]       duty_cycle;
  logic             valid, stuck, overrun;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .period     (period),
    .high_time  (high_time),
    .duty_cycle (duty_cycle),
    .valid      (valid),
    .stuck      (stuck),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int per;
    int hi;
    int duty;
    int stk;
  } exp_t;

  exp_t exp_q[$];
  int   ov_q[$];
  int   checks = 0;
  int   failures = 0;

  // Behavioural model state, in detected-edge cycle numbers.
  bit m_armed = 1'b0;
  int m_last_rise = 0;
  int m_hi = 0;
  int m_div_start = -1000000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_rise(input int d);
    exp_t e;
    if (m_armed && d > m_div_start && d < m_div_start + LAT) begin
      ov_q.push_back(d + 1);
    end else if (m_armed) begin
      e.cyc  = d + LAT;
      e.per  = d - m_last_rise;
      e.hi   = m_hi;
      e.duty = (m_hi * 100) / e.per;
      if (e.duty > 100) e.duty = 100;
      e.stk  = 0;
      exp_q.push_back(e);
      m_div_start = d;
    end else begin
      m_armed = 1'b1;
    end
    m_last_rise = d;
  endtask

  // Edges on the pin are seen by the design two cycles later.
  task automatic set_pin(input logic v);
    int d;
    d = cyc + 2;
    if (v && !pwm_in) model_rise(d);
    else if (!v && pwm_in) m_hi = (d - m_last_rise > TIMEOUT) ? TIMEOUT : d - m_last_rise;
    pwm_in = v;
  endtask

  task automatic expect_timeout(input bit level);
    exp_t e;
    e.cyc  = m_last_rise + TIMEOUT + 1;
    e.per  = 0;
    e.hi   = 0;
    e.duty = level ? 100 : 0;
    e.stk  = 1;
    exp_q.push_back(e);
    m_armed = 1'b0;
  endtask

  task automatic run_pwm(input int hi, input int per, input int n);
    for (int i = 0; i < n; i++) begin
      if (hi > 0) begin
        set_pin(1'b1);
        repeat (hi) tick();
      end
      set_pin(1'b0);
      repeat (per - hi) tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_period"}, 32'(period), 32'd0);
    check({tag, "_high_time"}, 32'(high_time), 32'd0);
    check({tag, "_duty"}, 32'(duty_cycle), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_stuck"}, 32'(stuck), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // Scoreboard side: compare every result pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'd0, 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("valid_cycle", 32'(cyc), 32'(e.cyc));
          check("period", 32'(period), 32'(e.per));
          check("high_time", 32'(high_time), 32'(e.hi));
          check("duty_cycle", 32'(duty_cycle), 32'(e.duty));
          check("stuck_on_valid", 32'(stuck), 32'(e.stk));
        end
      end
      if (overrun === 1'b1) begin
        if (ov_q.size() == 0) check("spurious_overrun", 32'd0, 32'd1);
        else check("overrun_cycle", 32'(cyc), 32'(ov_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset state.
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    m_last_rise = cyc;

    // Input stays low from reset: timeout with duty 0.
    expect_timeout(1'b0);
    repeat (TIMEOUT + 20) tick();
    check("stuck_low", 32'(stuck), 32'd1);
    check("stuck_low_duty", 32'(duty_cycle), 32'd0);

    // Generator loopback, period 100, several duty values.
    run_pwm(25, 100, 5);
    run_pwm(1, 100, 3);
    run_pwm(50, 100, 3);
    run_pwm(99, 100, 3);

    // Hold high after a measurement: timeout reporting duty 100.
    set_pin(1'b1);
    expect_timeout(1'b1);
    repeat (TIMEOUT + 40) tick();
    check("stuck_high", 32'(stuck), 32'd1);
    check("stuck_high_duty", 32'(duty_cycle), 32'd100);
    check("stuck_high_period", 32'(period), 32'd0);

    // Resume with high 3 / period 7 (overruns while the divider is busy).
    set_pin(1'b0);
    repeat (5) tick();
    run_pwm(3, 7, 8);
    check("stuck_cleared", 32'(stuck), 32'd0);

    // Period 10, shorter than the divide latency.
    run_pwm(3, 10, 8);

    // Reset in the middle of a divide.
    set_pin(1'b0);
    repeat (60) tick();
    set_pin(1'b1);
    repeat (25) tick();
    set_pin(1'b0);
    repeat (75) tick();
    set_pin(1'b1);
    repeat (10) tick();
    set_pin(1'b0);
    if (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (3) tick();
    m_armed = 1'b0;
    m_div_start = -1000000;
    rst_n = 1'b1;
    m_last_rise = cyc;
    repeat (5) tick();
    run_pwm(25, 100, 3);

    // Let outstanding results arrive, bounded.
    for (int i = 0; i < 500 && (exp_q.size() != 0 || ov_q.size() != 0); i++) tick();
    check("results_outstanding", 32'(exp_q.size()), 32'd0);
    check("overruns_outstanding", 32'(ov_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
